// File: rtl/sgndiv_pkg.sv
// sgndiv_pkg: shared definitions for the signed divider family.
//   sgndiv_state_e : control sequence IDLE -> ABS -> DIV -> FIX
//   sgndiv_err_e   : error classification latched before the iteration starts
//   err_flag()     : collapses an error code to the single o_err bit
package sgndiv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ABS  = 2'd1,
    ST_DIV  = 2'd2,
    ST_FIX  = 2'd3
  } sgndiv_state_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0,
    ERR_ZERO = 2'd1,
    ERR_OVF  = 2'd2
  } sgndiv_err_e;

  function automatic logic err_flag(input sgndiv_err_e e);
    return (e != ERR_NONE);
  endfunction

endpackage

// File: rtl/sgndiv_if.sv
// sgndiv_if: request/result bundle of the signed divider.
//   i_wr/i_n/i_d/i_aux            : request (driven by master)
//   o_busy/o_valid/o_q/o_r/o_err/o_aux : status and result (driven by slave)
//   master : requester side, slave : divider side
interface sgndiv_if #(
  parameter int NN = 24,
  parameter int ND = 12
);
  logic                 i_wr;
  logic signed [NN-1:0] i_n;
  logic signed [ND-1:0] i_d;
  logic                 i_aux;
  logic                 o_busy;
  logic                 o_valid;
  logic signed [NN-1:0] o_q;
  logic signed [ND-1:0] o_r;
  logic                 o_err;
  logic                 o_aux;

  modport master (
    output i_wr, i_n, i_d, i_aux,
    input  o_busy, o_valid, o_q, o_r, o_err, o_aux
  );

  modport slave (
    input  i_wr, i_n, i_d, i_aux,
    output o_busy, o_valid, o_q, o_r, o_err, o_aux
  );
endinterface

// File: rtl/sgndiv_udiv_core.sv
// sgndiv_udiv_core: unsigned restoring divider, one quotient bit per clock.
//   i_clk, i_reset : clock, synchronous active-high reset
//   i_start        : load magnitudes i_n/i_d and begin NN iterations
//   o_done         : high during the final iteration cycle
//   o_q            : unsigned quotient (valid the cycle after o_done)
//   o_r            : unsigned remainder, present only with SGNDIV_REM_EN
module sgndiv_udiv_core #(
  parameter int NN = 24,
  parameter int ND = 12
) (
  input  logic          i_clk,
  input  logic          i_reset,
  input  logic          i_start,
  input  logic [NN-1:0] i_n,
  input  logic [ND-1:0] i_d,
  output logic          o_done,
  output logic [NN-1:0] o_q
`ifdef SGNDIV_REM_EN
  ,
  output logic [ND-1:0] o_r
`endif
);

  localparam int CW = $clog2(NN);

  logic          run_q, run_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [NN-1:0] nq_q, nq_d;
  logic [ND-1:0] rem_q, rem_d;
  logic [ND-1:0] dv_q, dv_d;
  logic [ND:0]   shifted;
  logic [ND:0]   diff;
  logic          qbit;

  // nq_q doubles as numerator shifter and quotient accumulator: each step
  // consumes its MSB and appends the new quotient bit at the LSB.
  // The partial remainder stays below |d| <= 2^(ND-1), so the shifted value
  // fits ND bits and bit ND of the difference is a valid borrow/sign.
  always_comb begin
    run_d   = run_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    rem_d   = rem_q;
    dv_d    = dv_q;
    shifted = {rem_q, nq_q[NN-1]};
    diff    = shifted - {1'b0, dv_q};
    qbit    = ~diff[ND];
    if (i_start) begin
      run_d = 1'b1;
      cnt_d = CW'(NN - 1);
      nq_d  = i_n;
      rem_d = '0;
      dv_d  = i_d;
    end else if (run_q) begin
      nq_d  = {nq_q[NN-2:0], qbit};
      rem_d = qbit ? diff[ND-1:0] : shifted[ND-1:0];
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == '0) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      run_q <= 1'b0;
      cnt_q <= '0;
      nq_q  <= '0;
      rem_q <= '0;
      dv_q  <= '0;
    end else begin
      run_q <= run_d;
      cnt_q <= cnt_d;
      nq_q  <= nq_d;
      rem_q <= rem_d;
      dv_q  <= dv_d;
    end
  end

  assign o_done = run_q && (cnt_q == '0);
  assign o_q    = nq_q;
`ifdef SGNDIV_REM_EN
  assign o_r    = rem_q;
`endif

endmodule

// File: rtl/sgndiv.sv
// sgndiv: sequential signed divider, latency NN+2 clocks, truncating quotient.
//   i_clk, i_reset : clock, synchronous active-high reset
//   bus (slave)    : i_wr/i_n/i_d/i_aux request, accepted while o_busy is low;
//                    o_valid one-cycle result pulse with o_q/o_r/o_err/o_aux,
//                    results hold until the next completion.
// Build option: SGNDIV_REM_EN builds the signed remainder path; without it
// o_r is tied to zero.
module sgndiv
  import sgndiv_pkg::*;
#(
  parameter int NN = 24,
  parameter int ND = 12
) (
  input logic     i_clk,
  input logic     i_reset,
  sgndiv_if.slave bus
);

  localparam logic [NN-1:0] Q_MAX = {1'b0, {(NN-1){1'b1}}};
  localparam logic [NN-1:0] Q_MIN = {1'b1, {(NN-1){1'b0}}};

  sgndiv_state_e state_q, state_d;
  logic [NN-1:0] n_q, n_d;
  logic [ND-1:0] d_q, d_d;
  logic          aux_q, aux_d;
  logic          q_sgn_q, q_sgn_d;
  logic          r_sgn_q, r_sgn_d;
  sgndiv_err_e   err_q, err_d;
  logic          valid_q, valid_d;
  logic [NN-1:0] q_q, q_d;
  logic          oerr_q, oerr_d;
  logic          oaux_q, oaux_d;
`ifdef SGNDIV_REM_EN
  logic [ND-1:0] r_q, r_d;
  logic [ND-1:0] ur;
`endif

  logic [NN-1:0] abs_n;
  logic [ND-1:0] abs_d;
  logic [NN-1:0] uq;
  logic          core_start;
  logic          core_done;

  sgndiv_udiv_core #(
    .NN(NN),
    .ND(ND)
  ) u_core (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_start (core_start),
    .i_n     (abs_n),
    .i_d     (abs_d),
    .o_done  (core_done),
    .o_q     (uq)
`ifdef SGNDIV_REM_EN
    ,
    .o_r     (ur)
`endif
  );

  always_comb begin
    state_d    = state_q;
    n_d        = n_q;
    d_d        = d_q;
    aux_d      = aux_q;
    q_sgn_d    = q_sgn_q;
    r_sgn_d    = r_sgn_q;
    err_d      = err_q;
    valid_d    = 1'b0;
    q_d        = q_q;
    oerr_d     = oerr_q;
    oaux_d     = oaux_q;
`ifdef SGNDIV_REM_EN
    r_d        = r_q;
`endif
    core_start = 1'b0;
    // Magnitudes as NN/ND-bit unsigned: the most negative value maps to 2^(W-1).
    abs_n      = n_q[NN-1] ? ('0 - n_q) : n_q;
    abs_d      = d_q[ND-1] ? ('0 - d_q) : d_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.i_wr) begin
          n_d     = bus.i_n;
          d_d     = bus.i_d;
          aux_d   = bus.i_aux;
          state_d = ST_ABS;
        end
      end
      ST_ABS: begin
        // The core latches the magnitudes on this edge; the iteration still
        // runs on error so latency never depends on the operands.
        core_start = 1'b1;
        q_sgn_d    = n_q[NN-1] ^ d_q[ND-1];
        r_sgn_d    = n_q[NN-1];
        if (d_q == '0) begin
          err_d = ERR_ZERO;
        end else if ((n_q == Q_MIN) && (d_q == '1)) begin
          err_d = ERR_OVF;
        end else begin
          err_d = ERR_NONE;
        end
        state_d = ST_DIV;
      end
      ST_DIV: begin
        if (core_done) begin
          state_d = ST_FIX;
        end
      end
      ST_FIX: begin
        valid_d = 1'b1;
        oaux_d  = aux_q;
        oerr_d  = err_flag(err_q);
        unique case (err_q)
          ERR_ZERO: q_d = r_sgn_q ? Q_MIN : Q_MAX;
          ERR_OVF:  q_d = Q_MAX;
          default:  q_d = q_sgn_q ? ('0 - uq) : uq;
        endcase
`ifdef SGNDIV_REM_EN
        if (err_flag(err_q)) begin
          r_d = '0;
        end else begin
          r_d = r_sgn_q ? ('0 - ur) : ur;
        end
`endif
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      n_q     <= '0;
      d_q     <= '0;
      aux_q   <= 1'b0;
      q_sgn_q <= 1'b0;
      r_sgn_q <= 1'b0;
      err_q   <= ERR_NONE;
      valid_q <= 1'b0;
      q_q     <= '0;
      oerr_q  <= 1'b0;
      oaux_q  <= 1'b0;
`ifdef SGNDIV_REM_EN
      r_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      d_q     <= d_d;
      aux_q   <= aux_d;
      q_sgn_q <= q_sgn_d;
      r_sgn_q <= r_sgn_d;
      err_q   <= err_d;
      valid_q <= valid_d;
      q_q     <= q_d;
      oerr_q  <= oerr_d;
      oaux_q  <= oaux_d;
`ifdef SGNDIV_REM_EN
      r_q     <= r_d;
`endif
    end
  end

  // Busy drops on the edge that raises o_valid, so the o_valid cycle accepts.
  assign bus.o_busy  = (state_q != ST_IDLE);
  assign bus.o_valid = valid_q;
  assign bus.o_q     = q_q;
  assign bus.o_err   = oerr_q;
  assign bus.o_aux   = oaux_q;
`ifdef SGNDIV_REM_EN
  assign bus.o_r     = r_q;
`else
  assign bus.o_r     = '0;
`endif

endmodule

// File: doc/sgndiv.md
# sgndiv

Sequential signed integer divider built as the inverse companion of the signed multiply path. It converts signed operands to magnitudes, runs an unsigned restoring-division core one quotient bit per clock, then restores signs. It sits beside the multiplier cores in the arithmetic library and carries an auxiliary tag bit through with each result.

## Interface
- NN, 24, numerator and quotient width, signed, NN ≥ 4
- ND, 12, denominator and remainder width, signed, 2 ≤ ND ≤ NN
- i_clk  input  1  clock
- i_reset  input  1  synchronous, active-high reset
- i_wr  input  1  request; accepted when o_busy is low
- i_n  input  NN  signed numerator
- i_d  input  ND  signed denominator
- i_aux  input  1  tag captured on accept
- o_busy  output  1  division in progress; new requests ignored
- o_valid  output  1  one-cycle pulse; results valid
- o_q  output  NN  signed quotient
- o_r  output  ND  signed remainder
- o_err  output  1  divide-by-zero or overflow, qualified by o_valid
- o_aux  output  1  tag of the request being reported

## Operation
- States: IDLE, ABS, DIV, FIX.
- IDLE: i_wr=1 with o_busy=0 captures i_n, i_d, i_aux and goes to ABS. A request is also accepted in the o_valid cycle.
- ABS: registers |n| (NN-bit unsigned; -2^(NN-1) maps to 2^(NN-1)) and |d| (ND-bit unsigned). Also registers q_sgn = n[NN-1]^d[ND-1], r_sgn = n[NN-1], zero = (d==0), ovf = (n==-2^(NN-1) && d==-1). Goes to DIV with the iteration counter set to NN-1.
- DIV: one restoring step per clock. Partial remainder is ND+1 bits. Shift in the next numerator MSB, trial-subtract |d|, set the quotient bit if the result is non-negative. Counter decrements; at 0 the state goes to FIX.
- FIX: o_q = q_sgn ? -uq : uq and o_r = r_sgn ? -ur : ur, so the quotient truncates toward zero and the remainder takes the numerator's sign. Pulses o_valid and returns to IDLE.
- Error override in FIX:
  - zero: o_err=1, o_q = n≥0 ? 2^(NN-1)-1 : -2^(NN-1), o_r = 0.
  - ovf: o_err=1, o_q = 2^(NN-1)-1, o_r = 0.
  - Otherwise o_err=0.
- Latency stays constant even on error.
- i_wr while o_busy=1 is dropped with no side effects.
- o_q, o_r, o_err and o_aux hold their values until the next FIX.

## Timing
- Accept at clock edge t. o_busy is high from t+1 until the edge that asserts o_valid.
- o_valid is high for the single cycle following edge t+NN+2: latency NN+2 clocks, 26 at defaults.
- Throughput is one division per NN+2 clocks, with back-to-back requests accepted in the o_valid cycle.
- Reset values: state IDLE, o_busy=0, o_valid=0, o_q=0, o_r=0, o_err=0, o_aux=0.
- Reset mid-operation aborts silently: no o_valid, and the in-flight request is lost.
- Reset wins over a simultaneous i_wr.

## Configuration
- SGNDIV_REM_EN defined: remainder sign-fix and the o_r register are built; o_r behaves as above.
- SGNDIV_REM_EN undefined: o_r is driven constant 0 and the remainder negation logic is omitted. The quotient, o_err and the timing are unchanged.

## Structure
- Shared package: state encoding (IDLE/ABS/DIV/FIX) and error-code constants, shared with future divider variants.
- Sub-module udiv_core holds the unsigned restoring iteration: magnitudes in, uq/ur out, with start/done handshake.
- The top level owns sign handling, error detection, aux and output registers.

## Test plan
- n=100, d=7 -> after 26 clocks, o_q=14, o_r=2, o_err=0.
- n=-100, d=7 -> o_q=-14, o_r=-2. Then n=100, d=-7 -> o_q=-14, o_r=2.
- n=-8388608, d=-1 -> o_err=1, o_q=0x7FFFFF, o_r=0. Also n=-8388608, d=-2048 -> o_q=4096, o_r=0.
- n=5, d=0 -> o_err=1, o_q=0x7FFFFF. Then n=-5, d=0 -> o_q=0x800000. Latency is 26 in both cases.
- i_wr pulsed at clocks 3 and 10 of a busy division -> the second request is ignored and exactly one o_valid is produced. A new request in the o_valid cycle is accepted and its result arrives 26 clocks later, with o_aux tracking each request's tag.
- Assert i_reset at DIV cycle 12 -> no o_valid, all outputs 0. The next request completes correctly.
